// File: rtl/midi_pkg.sv
// midi_pkg: MIDI status constants, serial timing default, message-length decode and FSM state types.
package midi_pkg;
    localparam int CLKS_PER_BIT_DEFAULT = 1600;
    localparam logic [7:0] NOTE_OFF         = 8'h80;
    localparam logic [7:0] NOTE_ON          = 8'h90;
    localparam logic [7:0] POLY_PRESSURE    = 8'hA0;
    localparam logic [7:0] CONTROL_CHANGE   = 8'hB0;
    localparam logic [7:0] PROGRAM_CHANGE   = 8'hC0;
    localparam logic [7:0] CHANNEL_PRESSURE = 8'hD0;
    localparam logic [7:0] PITCH_BEND       = 8'hE0;
    localparam logic [7:0] SYSEX            = 8'hF0;
    localparam logic [7:0] MTC_QUARTER      = 8'hF1;
    localparam logic [7:0] SONG_POSITION    = 8'hF2;
    localparam logic [7:0] SONG_SELECT      = 8'hF3;
    localparam logic [7:0] TIMING_CLOCK     = 8'hF8;
    typedef enum logic [1:0] {C_IDLE, C_STATUS, C_D1, C_D2} ctrl_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;
    function automatic logic [1:0] msg_len(input logic [7:0] s);
        return !s[7] ? 2'd1 :
               (s[7:4] == PROGRAM_CHANGE[7:4] || s[7:4] == CHANNEL_PRESSURE[7:4] ||
                s == MTC_QUARTER || s == SONG_SELECT) ? 2'd2 :
               (s[7:4] != SYSEX[7:4] || s == SONG_POSITION) ? 2'd3 : 2'd1;
    endfunction
endpackage

// File: rtl/midi_uart_tx.sv
// midi_uart_tx: 8N1 LSB-first byte serializer; a new byte may be loaded in the last stop-bit cycle.
module midi_uart_tx import midi_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       idle
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    ser_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] sh;
    logic tick, load;
    always_comb begin
        tick = cnt == LAST;
        idle = state == S_IDLE;
        done = state == S_STOP && tick;
        load = start && (idle || done);
        tx = state == S_START ? 1'b0 : state == S_DATA ? sh[0] : 1'b1;
        nxt = state;
        if (load) nxt = S_START;
        else if (tick) nxt = state == S_START ? S_DATA : state == S_DATA ? (&bit_idx ? S_STOP : S_DATA) : S_IDLE;
    end
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            sh <= '0;
        end else begin
            state <= nxt;
            cnt <= (idle || tick) ? '0 : cnt + 1'b1;
            if (load) sh <= data;
            else if (tick && state == S_DATA) begin
                sh <= sh >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/midi_tx.sv
// midi_tx: MIDI message transmitter; message length derived from the status byte.
// Optional running-status suppression when MIDI_RUNNING_STATUS_EN is defined.
module midi_tx import midi_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    output logic       MIDI_OUT,
    output logic       busy,
    output logic       byte_sent
);
    ctrl_state_t state, nxt, sel;
    logic [7:0] st, d1, d2, ser_byte;
    logic [1:0] len;
    logic accept, skip, ser_start, ser_done, ser_idle;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] rs;
    // Channel-voice statuses set running status, F0-F7 clear it, real-time and raw bytes leave it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) rs <= '0;
        else if (accept && msg_status[7]) rs <= msg_status[7:4] != 4'hF ? msg_status : msg_status[3] ? rs : '0;
    end
    assign skip = msg_status[7] && msg_status[7:4] != 4'hF && msg_status == rs;
`else
    assign skip = 1'b0;
`endif
    always_comb begin
        msg_ready = state == C_IDLE;
        busy = !msg_ready;
        accept = msg_valid && msg_ready;
        len = msg_len(st);
        nxt = state;
        if (accept) nxt = skip ? C_D1 : C_STATUS;
        else if (ser_done) nxt = state == C_STATUS ? (len >= 2'd2 ? C_D1 : C_IDLE) :
                                 (state == C_D1 && len == 2'd3) ? C_D2 : C_IDLE;
        // First byte launches from an idle serializer; later bytes chain in the final stop cycle.
        ser_start = ser_idle ? state != C_IDLE : ser_done && nxt != C_IDLE;
        sel = ser_idle ? state : nxt;
        ser_byte = sel == C_STATUS ? st : sel == C_D1 ? d1 : d2;
    end
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= C_IDLE;
            st <= '0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                st <= msg_status;
                d1 <= msg_data1;
                d2 <= msg_data2;
            end
        end
    end
    midi_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .CLOCK_50(CLOCK_50),
        .reset_n(reset_n),
        .start(ser_start),
        .data(ser_byte),
        .tx(MIDI_OUT),
        .done(ser_done),
        .idle(ser_idle)
    );
    assign byte_sent = ser_done;
endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: directed checks of midi_tx framing, handshake, running status and reset.
module tb_midi_tx;
    localparam int C = 8;
    logic CLOCK_50, reset_n, msg_valid, msg_ready, MIDI_OUT, busy, byte_sent;
    logic [7:0] msg_status, msg_data1, msg_data2;
    int compared, mismatched;

    midi_tx #(.CLKS_PER_BIT(C)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
        .MIDI_OUT(MIDI_OUT), .busy(busy), .byte_sent(byte_sent)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
        msg_status = s;
        msg_data1 = a;
        msg_data2 = b;
        msg_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 msg_valid = 1'b0;
    endtask

    // Walks every cycle of an n-byte message starting just after the accepting edge.
    task automatic expect_msg(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input bit hold);
        logic [7:0] bytes [3];
        bytes = '{b0, b1, b2};
        @(negedge CLOCK_50);
        chk("line_before_start", MIDI_OUT, 1);
        chk("busy_after_accept", busy, 1);
        for (int i = 0; i < n * 10 * C; i++) begin
            int k, j;
            logic e;
            @(negedge CLOCK_50);
            k = i / (10 * C);
            j = (i / C) % 10;
            e = j == 0 ? 1'b0 : j == 9 ? 1'b1 : bytes[k][j-1];
            chk($sformatf("midi_out byte%0d bit%0d cyc%0d", k, j, i), MIDI_OUT, e);
            chk($sformatf("byte_sent cyc%0d", i), byte_sent, (i % (10 * C)) == 10 * C - 1);
            chk($sformatf("ready_low cyc%0d", i), msg_ready, 0);
            if (hold) begin
                msg_status = 8'h80 | 8'(i);
                msg_data1 = 8'(i);
                msg_data2 = ~8'(i);
            end
        end
    endtask

    task automatic expect_idle();
        @(negedge CLOCK_50);
        chk("ready_after_msg", msg_ready, 1);
        chk("busy_after_msg", busy, 0);
        chk("line_idle", MIDI_OUT, 1);
        chk("no_byte_sent", byte_sent, 0);
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        reset_n = 1'b0;
        msg_valid = 1'b0;
        msg_status = '0;
        msg_data1 = '0;
        msg_data2 = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_midi_out", MIDI_OUT, 1);
        chk("rst_ready", msg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_byte_sent", byte_sent, 0);
        reset_n = 1'b1;
        expect_idle();

        send(8'h90, 8'h3C, 8'h64);
        expect_msg(3, 8'h90, 8'h3C, 8'h64, 0);
        expect_idle();
        send(8'hC5, 8'h07, 8'h99);
        expect_msg(2, 8'hC5, 8'h07, 8'h00, 0);
        expect_idle();
        send(8'hF8, 8'h11, 8'h22);
        expect_msg(1, 8'hF8, 8'h00, 8'h00, 0);
        expect_idle();
        send(8'h42, 8'h11, 8'h22);
        expect_msg(1, 8'h42, 8'h00, 8'h00, 0);
        expect_idle();
        send(8'hF2, 8'h01, 8'h7F);
        expect_msg(3, 8'hF2, 8'h01, 8'h7F, 0);
        expect_idle();

        // valid held through busy with wandering inputs; next message taken when ready rises
        msg_status = 8'hD3;
        msg_data1 = 8'h55;
        msg_data2 = 8'hAA;
        msg_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        expect_msg(2, 8'hD3, 8'h55, 8'h00, 1);
        msg_status = 8'hB1;
        msg_data1 = 8'h07;
        msg_data2 = 8'h40;
        expect_idle();
        @(posedge CLOCK_50);
        #1 msg_valid = 1'b0;
        expect_msg(3, 8'hB1, 8'h07, 8'h40, 0);
        expect_idle();

        send(8'hA0, 8'h10, 8'h20);
        expect_msg(3, 8'hA0, 8'h10, 8'h20, 0);
        expect_idle();
        send(8'hF8, 8'h00, 8'h00);
        expect_msg(1, 8'hF8, 8'h00, 8'h00, 0);
        expect_idle();
        send(8'hA0, 8'h3E, 8'h64);
`ifdef MIDI_RUNNING_STATUS_EN
        expect_msg(2, 8'h3E, 8'h64, 8'h00, 0);
`else
        expect_msg(3, 8'hA0, 8'h3E, 8'h64, 0);
`endif
        expect_idle();
        send(8'hF0, 8'h00, 8'h00);
        expect_msg(1, 8'hF0, 8'h00, 8'h00, 0);
        expect_idle();
        send(8'hA0, 8'h3C, 8'h00);
        expect_msg(3, 8'hA0, 8'h3C, 8'h00, 0);
        expect_idle();

        // reset mid-byte: inside data bit 3 of 0x90, which is a 0 on the line
        send(8'h90, 8'h3C, 8'h64);
        repeat (38) @(negedge CLOCK_50);
        chk("mid_byte_line_low", MIDI_OUT, 0);
        chk("mid_byte_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_midi_out", MIDI_OUT, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", msg_ready, 1);
        chk("async_rst_byte_sent", byte_sent, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        send(8'h90, 8'h3C, 8'h64);
        expect_msg(3, 8'h90, 8'h3C, 8'h64, 0);
        expect_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
